// File: rtl/pin_entry_verifier_if.sv
// Keypad/PIN session bus between the ATM front panel and the PIN verifier.
interface pin_entry_verifier_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic [3:0]            digit_in;
  logic                  digit_valid;
  logic                  enter_key;
  logic                  clear_key;
  logic [4*DIGITS-1:0]   ref_pin;
  logic                  pin_ok;
  logic                  pin_bad;
  logic                  locked;
  logic                  timeout;
  logic                  busy;
  logic [2:0]            digit_count;

  modport master (
    output start, digit_in, digit_valid, enter_key, clear_key, ref_pin,
    input  pin_ok, pin_bad, locked, timeout, busy, digit_count
  );

  modport slave (
    input  start, digit_in, digit_valid, enter_key, clear_key, ref_pin,
    output pin_ok, pin_bad, locked, timeout, busy, digit_count
  );
endinterface

// File: rtl/pin_entry_verifier.sv
// PIN entry session: collects BCD digits, compares against the account PIN,
// counts wrong tries up to lockout and abandons idle entry on timeout.
module pin_entry_verifier #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  pin_entry_verifier_if.slave  bus
);

  localparam int unsigned BUF_W = 4 * DIGITS;
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [2:0]       FULL_CNT  = 3'(DIGITS);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_COMPARE = 3'd2;
  localparam logic [2:0] S_PASS    = 3'd3;
  localparam logic [2:0] S_FAIL    = 3'd4;
  localparam logic [2:0] S_LOCK    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tout_q, tout_d;

  logic             digit_acc;
  logic [TRY_W-1:0] try_inc;

  // A digit is taken only if it is valid BCD and the buffer has room.
  assign digit_acc = bus.digit_valid && (bus.digit_in <= 4'd9) && (cnt_q < FULL_CNT);
  assign try_inc   = tries_q + TRY_W'(1);

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    tmr_d   = tmr_q;
    tout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_COLLECT;
          buf_d   = '0;
          cnt_d   = '0;
          tries_d = '0;
          tmr_d   = '0;
        end
      end
      S_COLLECT: begin
        if (bus.clear_key) begin
          buf_d = '0;
          cnt_d = '0;
          tmr_d = '0;
        end else if (bus.enter_key && (cnt_q == FULL_CNT)) begin
          state_d = S_COMPARE;
        end else if (digit_acc) begin
          buf_d = (buf_q << 4) | BUF_W'(bus.digit_in);
          cnt_d = cnt_q + 3'd1;
          tmr_d = '0;
        end else if (tmr_q == TMR_LAST) begin
          state_d = S_IDLE;
          tout_d  = 1'b1;
          buf_d   = '0;
          cnt_d   = '0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_COMPARE: begin
        // The buffer is consumed here whatever the outcome.
        buf_d = '0;
        cnt_d = '0;
        tmr_d = '0;
        if (buf_q == bus.ref_pin) begin
          state_d = S_PASS;
        end else begin
          tries_d = try_inc;
          state_d = (try_inc == TRY_LIMIT) ? S_LOCK : S_FAIL;
        end
      end
      S_PASS: begin
        state_d = S_IDLE;
      end
      S_FAIL: begin
        state_d = S_COLLECT;
        buf_d   = '0;
        cnt_d   = '0;
        tmr_d   = '0;
      end
      S_LOCK: begin
        state_d = S_LOCK;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      tries_q <= '0;
      tmr_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      tmr_q   <= tmr_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.pin_ok      = (state_q == S_PASS);
  assign bus.pin_bad     = (state_q == S_FAIL);
  assign bus.locked      = (state_q == S_LOCK);
  assign bus.timeout     = tout_q;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_LOCK);
  assign bus.digit_count = cnt_q;

endmodule

// File: tb/tb_pin_entry_verifier.sv
// Directed bench for pin_entry_verifier: pass, lockout, clear/invalid keys,
// timeout, key priority and reset during compare.
module tb_pin_entry_verifier;

  localparam int unsigned TB_TIMEOUT = 20;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  pin_entry_verifier_if #(.DIGITS(4)) bus ();

  pin_entry_verifier #(
    .DIGITS(4),
    .MAX_TRIES(3),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    bus.digit_in    = d;
    bus.digit_valid = 1'b1;
    tick();
    bus.digit_valid = 1'b0;
  endtask

  task automatic press_enter();
    bus.enter_key = 1'b1;
    tick();
    bus.enter_key = 1'b0;
  endtask

  task automatic press_clear();
    bus.clear_key = 1'b1;
    tick();
    bus.clear_key = 1'b0;
  endtask

  task automatic begin_session();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wrong_attempt();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    press_enter();
  endtask

  initial begin
    int pulses;
    int first_at;
    n_checks = 0;
    n_errors = 0;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.digit_in    = 4'd0;
    bus.digit_valid = 1'b0;
    bus.enter_key   = 1'b0;
    bus.clear_key   = 1'b0;
    bus.ref_pin     = 16'h1010;
    tick();
    tick();
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_outs",   32'({bus.pin_ok, bus.pin_bad, bus.timeout}), 32'd0);
    check("rst_count",  32'(bus.digit_count), 32'd0);
    reset = 1'b0;
    tick();

    // Correct PIN: pin_ok two cycles after enter, then idle
    begin_session();
    check("t1_busy", 32'(bus.busy), 32'd1);
    key(4'd1); key(4'd0); key(4'd1); key(4'd0);
    check("t1_count4", 32'(bus.digit_count), 32'd4);
    press_enter();
    check("t1_cmp_ok", 32'(bus.pin_ok), 32'd0);
    tick();
    check("t1_pin_ok", 32'(bus.pin_ok), 32'd1);
    check("t1_pin_bad", 32'(bus.pin_bad), 32'd0);
    tick();
    check("t1_ok_gone", 32'(bus.pin_ok), 32'd0);
    check("t1_idle", 32'(bus.busy), 32'd0);

    // Three wrong attempts lead to lockout
    begin_session();
    for (int a = 1; a <= 3; a++) begin
      wrong_attempt();
      check("t2_cmp_bad", 32'(bus.pin_bad), 32'd0);
      tick();
      if (a < 3) begin
        check("t2_pin_bad", 32'(bus.pin_bad), 32'd1);
        check("t2_not_lock", 32'(bus.locked), 32'd0);
        tick();
        check("t2_bad_gone", 32'(bus.pin_bad), 32'd0);
        check("t2_collect", 32'(bus.busy), 32'd1);
      end else begin
        check("t2_locked", 32'(bus.locked), 32'd1);
        check("t2_no_bad", 32'(bus.pin_bad), 32'd0);
        check("t2_lock_busy", 32'(bus.busy), 32'd0);
      end
    end
    begin_session();
    key(4'd3);
    check("t2_start_ign", 32'({bus.locked, bus.busy}), 32'b10);
    check("t2_lock_cnt", 32'(bus.digit_count), 32'd0);
    reset = 1'b1;
    #1;
    check("t2_rst_unlock", 32'(bus.locked), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Clear, invalid digit and overflow digit
    begin_session();
    key(4'd1); key(4'd0);
    check("t3_count2", 32'(bus.digit_count), 32'd2);
    press_clear();
    check("t3_cleared", 32'(bus.digit_count), 32'd0);
    key(4'd1); key(4'd0); key(4'd1);
    key(4'hC);
    check("t3_bcd_ign", 32'(bus.digit_count), 32'd3);
    key(4'd0);
    key(4'd5);
    check("t3_fifth_ign", 32'(bus.digit_count), 32'd4);
    press_enter();
    tick();
    check("t3_pin_ok", 32'(bus.pin_ok), 32'd1);
    tick();

    // Idle entry times out exactly once after TB_TIMEOUT cycles
    begin_session();
    pulses = 0;
    first_at = 0;
    for (int i = 1; i <= TB_TIMEOUT + 10; i++) begin
      tick();
      if (bus.timeout) begin
        pulses++;
        if (first_at == 0) first_at = i;
      end
    end
    check("t4_pulses", 32'(pulses), 32'd1);
    check("t4_when", 32'(first_at), 32'(TB_TIMEOUT));
    check("t4_idle", 32'(bus.busy), 32'd0);

    // Clear beats enter and digit in the same cycle
    begin_session();
    key(4'd1); key(4'd0); key(4'd1); key(4'd0);
    bus.clear_key   = 1'b1;
    bus.enter_key   = 1'b1;
    bus.digit_valid = 1'b1;
    bus.digit_in    = 4'd5;
    tick();
    bus.clear_key   = 1'b0;
    bus.enter_key   = 1'b0;
    bus.digit_valid = 1'b0;
    check("t5_count0", 32'(bus.digit_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_cmp", 32'({bus.pin_ok, bus.pin_bad, bus.busy}), 32'b001);
    end

    // Reset during COMPARE aborts silently
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    begin_session();
    key(4'd1); key(4'd0); key(4'd1); key(4'd0);
    press_enter();
    reset = 1'b1;
    #1;
    check("t6_rst_outs", 32'({bus.pin_ok, bus.pin_bad, bus.locked, bus.timeout, bus.busy}), 32'd0);
    check("t6_rst_cnt", 32'(bus.digit_count), 32'd0);
    tick();
    check("t6_rst_hold", 32'({bus.pin_ok, bus.pin_bad}), 32'd0);
    reset = 1'b0;
    tick();
    check("t6_after", 32'({bus.pin_ok, bus.pin_bad, bus.busy}), 32'd0);
    tick();
    check("t6_after2", 32'({bus.pin_ok, bus.pin_bad, bus.busy}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
